vga_capture: RTL and testbench

- Receive side of the VGA pixel interface: samples an incoming VGA-style stream (RGB, active-low H/V sync, blank_n) on the pixel clock.
- Recovers pixel coordinates and qualifies pixels against the expected active resolution.
- Emits a valid-qualified 24-bit pixel stream with frame/line markers.
- Sits in front of frame-buffer writers and loopback checkers that verify the VGA output path.

---
 rtl/vga_capture.sv | 202 ++++++++++++++++++++
 tb/tb_vga_capture.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_capture.sv
// VGA receive front end: registers the incoming stream, recovers x/y, checks timing
// against H_ACTIVE x V_ACTIVE and emits a lock-qualified pixel stream. Define VGA_CAP_CHECKSUM_EN for per-frame CRC.
module vga_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int CNT_W       = 11,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_R,
  input  logic [7:0]       i_G,
  input  logic [7:0]       i_B,
  input  logic             i_H_sync,
  input  logic             i_V_sync,
  input  logic             i_blank_n,
  output logic [23:0]      o_pixel,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic             o_sof,
  output logic             o_eol,
  output logic             o_locked,
  output logic [CNT_W-1:0] o_h_total,
  output logic [CNT_W-1:0] o_v_total,
`ifdef VGA_CAP_CHECKSUM_EN
  output logic [15:0]      o_crc,
  output logic             o_crc_valid,
`endif
  output logic             o_err
);
  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] HA   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HL   = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] VA   = CNT_W'(V_ACTIVE);
  localparam logic [GW-1:0]    LF   = GW'(LOCK_FRAMES);

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;
  state_t state_q;

  logic [23:0]      pix1_q;
  logic             hs1_q, vs1_q, bl1_q, hs_prev_q, vs_prev_q;
  logic [CNT_W-1:0] h_cnt_q, x_q, y_q, lines_q;
  logic             line_act_q, frame_bad_q;
  logic [GW-1:0]    good_q;

  logic             hs_start, vs_start, act_end, line_bad, frame_ok, pix_ok;
  logic [CNT_W-1:0] x_cur, y_cur;

  assign hs_start = hs_prev_q & ~hs1_q;
  assign vs_start = vs_prev_q & ~vs1_q;

  // Coordinates of the pixel now in stage 1, with this cycle's sync events applied
  always_comb begin
    x_cur    = hs_start ? '0 : x_q;
    act_end  = hs_start && line_act_q;
    line_bad = act_end && (x_q != HA);
    y_cur    = y_q;
    if (vs_start)                   y_cur = '0;
    else if (act_end && y_q != CMAX) y_cur = y_q + ONE;
    frame_ok = !frame_bad_q && !line_bad &&
               (({1'b0, y_q} + {{CNT_W{1'b0}}, act_end}) == {1'b0, VA});
    pix_ok   = bl1_q && (x_cur < HA) && (y_cur < VA);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pix1_q      <= '0;
      hs1_q       <= 1'b1;
      vs1_q       <= 1'b1;
      bl1_q       <= 1'b0;
      hs_prev_q   <= 1'b1;
      vs_prev_q   <= 1'b1;
      h_cnt_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      lines_q     <= '0;
      line_act_q  <= 1'b0;
      frame_bad_q <= 1'b0;
      o_h_total   <= '0;
      o_v_total   <= '0;
    end else begin
      pix1_q    <= {i_R, i_G, i_B};
      hs1_q     <= i_H_sync;
      vs1_q     <= i_V_sync;
      bl1_q     <= i_blank_n;
      hs_prev_q <= hs1_q;
      vs_prev_q <= vs1_q;
      if (hs_start) begin
        o_h_total <= (h_cnt_q == CMAX) ? CMAX : h_cnt_q + ONE;
        h_cnt_q   <= '0;
      end else if (h_cnt_q != CMAX) begin
        h_cnt_q <= h_cnt_q + ONE;
      end
      x_q        <= (bl1_q && x_cur != CMAX) ? x_cur + ONE : x_cur;
      y_q        <= y_cur;
      line_act_q <= (hs_start || vs_start) ? bl1_q : (line_act_q | bl1_q);
      // A line starting on the vsync edge belongs to the new frame's line count
      if (vs_start) begin
        o_v_total <= lines_q;
        lines_q   <= hs_start ? ONE : '0;
      end else if (hs_start && lines_q != CMAX) begin
        lines_q <= lines_q + ONE;
      end
      frame_bad_q <= vs_start ? 1'b0 : (frame_bad_q | line_bad);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      good_q   <= '0;
      o_locked <= 1'b0;
      o_err    <= 1'b0;
      o_valid  <= 1'b0;
      o_sof    <= 1'b0;
      o_eol    <= 1'b0;
      o_pixel  <= '0;
      o_x      <= '0;
      o_y      <= '0;
    end else begin
      o_pixel <= pix1_q;
      o_x     <= x_cur;
      o_y     <= y_cur;
      o_valid <= 1'b0;
      o_sof   <= 1'b0;
      o_eol   <= 1'b0;
      // Runaway line count means vsync has gone missing: start over
      if (!vs_start && lines_q == CMAX) begin
        state_q  <= IDLE;
        o_locked <= 1'b0;
        good_q   <= '0;
      end else begin
        case (state_q)
          IDLE: if (vs_start) begin
            state_q <= MEASURE;
            good_q  <= '0;
          end
          MEASURE: if (vs_start) begin
            if (!frame_ok) begin
              good_q <= '0;
            end else if (good_q + GW'(1) == LF) begin
              state_q  <= LOCKED;
              o_locked <= 1'b1;
              good_q   <= '0;
            end else begin
              good_q <= good_q + GW'(1);
            end
          end
          LOCKED: begin
            if (vs_start ? !frame_ok : line_bad) begin
              state_q  <= MEASURE;
              good_q   <= '0;
              o_locked <= 1'b0;
              o_err    <= 1'b1;
            end else if (pix_ok) begin
              o_valid <= 1'b1;
              o_sof   <= (x_cur == '0) && (y_cur == '0);
              o_eol   <= (x_cur == HL);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef VGA_CAP_CHECKSUM_EN
  function automatic logic [15:0] crc_px(input logic [15:0] c, input logic [23:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 23; i >= 0; i--)
      r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    return r;
  endfunction

  logic [15:0] crc_acc_q, crc_fold;
  // Fold the pixel already in the output stage so the frame's last pixel is included
  assign crc_fold = o_valid ? crc_px(crc_acc_q, o_pixel) : crc_acc_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      crc_acc_q   <= 16'hFFFF;
      o_crc       <= '0;
      o_crc_valid <= 1'b0;
    end else begin
      o_crc_valid <= 1'b0;
      if (vs_start) begin
        crc_acc_q <= 16'hFFFF;
        if (state_q == LOCKED) begin
          o_crc       <= crc_fold;
          o_crc_valid <= 1'b1;
        end
      end else begin
        crc_acc_q <= crc_fold;
      end
    end
  end
`endif
endmodule

// File: tb/tb_vga_capture.sv
// Self-checking bench for vga_capture: 8x4 active in 12-clock lines, 6-line frames,
// frame-level lock model plus per-pixel scoreboard.
module tb_vga_capture;
  localparam int HA = 8, VA = 4, CW = 11, LINE = 12;

  logic clk = 1'b0, rst;
  logic [7:0] R, G, B;
  logic hs, vs, bl;
  logic [23:0] o_pixel;
  logic o_valid, o_sof, o_eol, o_locked, o_err;
  logic [CW-1:0] o_x, o_y, o_h_total, o_v_total;
`ifdef VGA_CAP_CHECKSUM_EN
  logic [15:0] o_crc;
  logic o_crc_valid;
`endif

  vga_capture #(.H_ACTIVE(HA), .V_ACTIVE(VA), .CNT_W(CW), .LOCK_FRAMES(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_R(R), .i_G(G), .i_B(B),
    .i_H_sync(hs), .i_V_sync(vs), .i_blank_n(bl),
    .o_pixel(o_pixel), .o_valid(o_valid), .o_x(o_x), .o_y(o_y),
    .o_sof(o_sof), .o_eol(o_eol), .o_locked(o_locked),
    .o_h_total(o_h_total), .o_v_total(o_v_total),
`ifdef VGA_CAP_CHECKSUM_EN
    .o_crc(o_crc), .o_crc_valid(o_crc_valid),
`endif
    .o_err(o_err));

  always #5 clk = ~clk;

  typedef struct { int t; int x; int y; logic [23:0] p; bit sof; bit eol; } exp_t;
  typedef struct { int t; logic [15:0] c; } crc_t;
  typedef struct { int w; int bad_idx; int bad_w; int mode; bit exp_lock; bit exp_err; bit chk_marks; } frame_t;

  exp_t q[$];
  crc_t cq[$];
  int n_chk = 0, n_fail = 0, cyc = 0, sof_cnt = 0, eol_cnt = 0;
  int m_state = 0, m_good = 0;
  bit m_locked = 0, m_err = 0, prev_ok = 0;
  logic [15:0] m_crc = 16'hFFFF;

  // Byte-wise CRC-16-CCITT over R, G, B
  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [23:0] p);
    logic [15:0] r;
    logic [7:0] by;
    r = c;
    for (int k = 2; k >= 0; k--) begin
      by = p[k*8 +: 8];
      r = r ^ {by, 8'h00};
      for (int b = 0; b < 8; b++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  task automatic chk(input string nm, input int a, input int e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  // One clock: advance, then compare outputs against the scoreboard
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (o_valid) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: got x=%0d y=%0d pix=%06h, none expected (cycle %0d)", o_x, o_y, o_pixel, cyc);
      end else begin
        e = q.pop_front();
        if (e.t != cyc || e.x != int'(o_x) || e.y != int'(o_y) || e.p !== o_pixel || e.sof != o_sof || e.eol != o_eol) begin
          n_fail++;
          $display("FAIL pixel: got t=%0d x=%0d y=%0d p=%06h sof=%0b eol=%0b expected t=%0d x=%0d y=%0d p=%06h sof=%0b eol=%0b",
                   cyc, o_x, o_y, o_pixel, o_sof, o_eol, e.t, e.x, e.y, e.p, e.sof, e.eol);
        end
      end
      sof_cnt += int'(o_sof);
      eol_cnt += int'(o_eol);
    end else begin
      if (q.size() > 0 && q[0].t <= cyc) begin
        e = q.pop_front();
        n_chk++; n_fail++;
        $display("FAIL missed_pixel: got no valid, expected x=%0d y=%0d at cycle %0d", e.x, e.y, e.t);
      end
      if (o_sof || o_eol) begin
        n_chk++; n_fail++;
        $display("FAIL marker_without_valid: got sof=%0b eol=%0b expected 0 0", o_sof, o_eol);
      end
    end
`ifdef VGA_CAP_CHECKSUM_EN
    if (o_crc_valid) begin
      n_chk++;
      if (cq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_crc_valid: got crc=%04h, none expected (cycle %0d)", o_crc, cyc);
      end else begin
        crc_t c = cq.pop_front();
        if (c.t != cyc || c.c !== o_crc) begin
          n_fail++;
          $display("FAIL crc: got %04h at %0d expected %04h at %0d", o_crc, cyc, c.c, c.t);
        end
      end
    end else if (cq.size() > 0 && cq[0].t <= cyc) begin
      crc_t c = cq.pop_front();
      n_chk++; n_fail++;
      $display("FAIL missed_crc: got no crc_valid, expected %04h at %0d", c.c, c.t);
    end
`endif
  endtask

  task automatic drive(input bit h, input bit v, input bit b, input logic [23:0] p);
    {R, G, B} = p; hs = h; vs = v; bl = b;
    tick();
  endtask

  // One 12-clock line: hsync low for clocks 0-1, w active pixels from clock 2
  task automatic drive_line(input bit vlow, input int w, input int y, input int mode,
                            input bit chk_edge, input bit pre, input bit exp_l, input bit exp_e);
    for (int c = 0; c < LINE; c++) begin
      bit b;
      int x;
      logic [23:0] p;
      x = c - 2;
      b = (c >= 2) && (c < 2 + w);
      case (mode)
        1:       p = 24'(x + 16 * y);
        2:       p = '0;
        default: p = 24'($urandom);
      endcase
      if (!b) p = 24'($urandom);
      if (b && m_locked && x < HA && y >= 0 && y < VA) begin
        q.push_back('{cyc + 2, x, y, p, (x == 0 && y == 0), (x == HA - 1)});
        m_crc = crc_ref(m_crc, p);
      end
      drive(c >= 2, !vlow, b, p);
      if (chk_edge && c == 0) chk("lock_before_edge", int'(o_locked), int'(pre));
      if (chk_edge && c == 1) begin
        chk("lock_after_edge", int'(o_locked), int'(exp_l));
        chk("err_after_edge", int'(o_err), int'(exp_e));
      end
    end
  endtask

  // Frame = vsync line, 4 active lines, 1 blank line; lock state tracked per frame
  task automatic send_frame(input frame_t f);
    bit pre, pend;
    int w;
    pre = m_locked;
    if (m_state == 2) cq.push_back('{cyc + 2, m_crc});
    case (m_state)
      0: begin m_state = 1; m_good = 0; end
      1: begin
        m_good = prev_ok ? m_good + 1 : 0;
        if (m_good == 2) begin m_state = 2; m_locked = 1; m_good = 0; end
      end
      default: if (!prev_ok) begin m_state = 1; m_good = 0; m_locked = 0; m_err = 1; end
    endcase
    m_crc = 16'hFFFF; prev_ok = 1; sof_cnt = 0; eol_cnt = 0;
    drive_line(1, 0, -1, 0, 1, pre, f.exp_lock, f.exp_err);
    pend = 0;
    for (int i = 0; i < 5; i++) begin
      w = (i < 4) ? ((i == f.bad_idx) ? f.bad_w : f.w) : 0;
      pre = m_locked;
      if (pend && m_locked) begin m_locked = 0; m_state = 1; m_good = 0; m_err = 1; end
      drive_line(0, w, i, f.mode, pend, pre, m_locked, m_err);
      pend = (i < 4) && (w != HA);
      if (pend) prev_ok = 0;
    end
    if (f.chk_marks) begin
      chk("sof_count", sof_cnt, 1);
      chk("eol_count", eol_cnt, 4);
    end
  endtask

  initial begin
    frame_t tbl[10];
    frame_t fin;
    //          w  bad bw mode lock err marks
    tbl[0] = '{8, -1, 0, 0, 0, 0, 0};
    tbl[1] = '{8, -1, 0, 0, 0, 0, 0};
    tbl[2] = '{8, -1, 0, 1, 1, 0, 1};
    tbl[3] = '{8,  2, 7, 0, 1, 0, 0};
    tbl[4] = '{10, -1, 0, 0, 0, 1, 0};
    tbl[5] = '{8, -1, 0, 0, 0, 1, 0};
    tbl[6] = '{8, -1, 0, 0, 0, 1, 0};
    tbl[7] = '{8, -1, 0, 2, 1, 1, 0};
    tbl[8] = '{8, -1, 0, 0, 1, 1, 0};
    tbl[9] = '{8, -1, 0, 0, 1, 1, 0};
    fin    = '{8, -1, 0, 0, 0, 1, 0};

    rst = 1; hs = 1; vs = 1; bl = 0; {R, G, B} = '0;
    repeat (3) tick();
    chk("rst_pixel", int'(o_pixel), 0);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_x", int'(o_x), 0);
    chk("rst_y", int'(o_y), 0);
    chk("rst_sof", int'(o_sof), 0);
    chk("rst_eol", int'(o_eol), 0);
    chk("rst_locked", int'(o_locked), 0);
    chk("rst_h_total", int'(o_h_total), 0);
    chk("rst_v_total", int'(o_v_total), 0);
    chk("rst_err", int'(o_err), 0);
    rst = 0;

    // Stream without vsync, then reset mid-line; no pixel may be emitted
    drive_line(0, 8, 0, 0, 0, 0, 0, 0);
    drive_line(0, 8, 1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 6; c++) drive(c >= 2, 1, c >= 2, 24'($urandom));
    rst = 1;
    repeat (3) drive(1, 1, 1, 24'($urandom));
    chk("midrst_h_total", int'(o_h_total), 0);
    chk("midrst_locked", int'(o_locked), 0);
    rst = 0;
    repeat (3) drive_line(0, 8, 0, 0, 0, 0, 0, 0);
    chk("idle_locked", int'(o_locked), 0);

    for (int k = 0; k < 10; k++) begin
      send_frame(tbl[k]);
      if (k == 2) begin
        chk("h_total", int'(o_h_total), LINE);
        chk("v_total", int'(o_v_total), 6);
      end
    end

    // Missing vsync: line count saturates and lock is dropped
    for (int i = 0; i < 2100; i++) drive_line(0, 0, 0, 0, 0, 0, 0, 0);
    m_state = 0; m_locked = 0; m_good = 0;
    chk("sat_unlock", int'(o_locked), 0);
    chk("sat_err_sticky", int'(o_err), 1);
    send_frame(fin);
    repeat (4) drive(1, 1, 0, '0);
    chk("pixels_drained", q.size(), 0);
`ifdef VGA_CAP_CHECKSUM_EN
    chk("crc_drained", cq.size(), 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
